// File: rtl/route_tagger.sv
// -----------------------------------------------------------------------------
// route_tagger
//   Transmit-side feeder for the 2-port router. Drains two source FIFOs
//   (8-bit payload + 2-bit destination each) under round-robin arbitration.
//   It pushes 10-bit tagged words {dest, data} into the router's ingress FIFO.
//
//   Pipeline:
//     cycle N   : pop strobe, computed combinationally from registered state
//     cycle N+1 : the popped source presents data/dest; dest is checked here
//     cycle N+2 : out_word / push are presented from registers
//
// Ports
//   clk              rising-edge clock
//   reset            synchronous, active-high reset
//   src0_empty       source FIFO 0 empty
//   src1_empty       source FIFO 1 empty
//   src0_data        source 0 payload, valid the cycle after pop_src0
//   src1_data        source 1 payload, valid the cycle after pop_src1
//   src0_dest        source 0 destination, valid with src0_data
//   src1_dest        source 1 destination, valid with src1_data
//   fifo_almost_full downstream ingress FIFO has fewer than 3 free entries
//   pop_src0         read strobe to source FIFO 0
//   pop_src1         read strobe to source FIFO 1
//   out_word         tagged word {dest, data}; valid only while push = 1
//   push             write strobe to the ingress FIFO
//   error            sticky flag: an illegal destination was seen
//   tx_count         words pushed since reset, wraps modulo 2^CNT_W
// -----------------------------------------------------------------------------
module route_tagger #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             src0_empty,
    input  logic             src1_empty,
    input  logic [7:0]       src0_data,
    input  logic [7:0]       src1_data,
    input  logic [1:0]       src0_dest,
    input  logic [1:0]       src1_dest,
    input  logic             fifo_almost_full,
    output logic             pop_src0,
    output logic             pop_src1,
    output logic [9:0]       out_word,
    output logic             push,
    output logic             error,
    output logic [CNT_W-1:0] tx_count
);

    typedef enum logic {
        SRC0 = 1'b0,
        SRC1 = 1'b1
    } src_e;

    // Arbitration state
    src_e             last_grant_q, last_grant_d;

    // Stage 1: a pop was issued last cycle, and from which source
    logic             s1_valid_q, s1_valid_d;
    src_e             s1_src_q, s1_src_d;

    // Output stage
    logic [9:0]       out_word_q, out_word_d;
    logic             push_q, push_d;
    logic             error_q, error_d;
    logic [CNT_W-1:0] tx_count_q, tx_count_d;

    // Arbitration and stage-1 capture
    logic eligible;
    logic grant0, grant1;

    // NOTE: every always_comb output gets a default before any branch, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        eligible = !fifo_almost_full && !reset;
        grant0   = 1'b0;
        grant1   = 1'b0;
        if (eligible) begin
            if (!src0_empty && !src1_empty) begin
                // Both sources want service: serve the one not granted last.
                if (last_grant_q == SRC1) grant0 = 1'b1;
                else                      grant1 = 1'b1;
            end else if (!src0_empty) begin
                grant0 = 1'b1;
            end else if (!src1_empty) begin
                grant1 = 1'b1;
            end
        end

        last_grant_d = last_grant_q;
        if (grant0)      last_grant_d = SRC0;
        else if (grant1) last_grant_d = SRC1;

        s1_valid_d = grant0 || grant1;
        s1_src_d   = grant1 ? SRC1 : SRC0;
    end

    assign pop_src0 = grant0;
    assign pop_src1 = grant1;

    // Destination check on the data the popped source presents this cycle
    logic [7:0] sel_data;
    logic [1:0] sel_dest;
    logic       dest_legal;

    always_comb begin
        sel_data   = (s1_src_q == SRC1) ? src1_data : src0_data;
        sel_dest   = (s1_src_q == SRC1) ? src1_dest : src0_dest;
        // Only router ports 0 and 1 exist; a set MSB is an illegal destination.
        dest_legal = !sel_dest[1];

        push_d     = s1_valid_q && dest_legal;
        out_word_d = push_d ? {sel_dest, sel_data} : out_word_q;
        tx_count_d = push_d ? tx_count_q + 1'b1 : tx_count_q;
        error_d    = error_q || (s1_valid_q && !dest_legal);
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant_q <= SRC1;   // source 0 wins the first contest
            s1_valid_q   <= 1'b0;   // drops any word already in flight
            s1_src_q     <= SRC0;
            out_word_q   <= '0;
            push_q       <= 1'b0;
            error_q      <= 1'b0;
            tx_count_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            s1_valid_q   <= s1_valid_d;
            s1_src_q     <= s1_src_d;
            out_word_q   <= out_word_d;
            push_q       <= push_d;
            error_q      <= error_d;
            tx_count_q   <= tx_count_d;
        end
    end

    assign out_word = out_word_q;
    assign push     = push_q;
    assign error    = error_q;
    assign tx_count = tx_count_q;

endmodule

// File: tb/tb_route_tagger.sv
// -----------------------------------------------------------------------------
// tb_route_tagger
//   Directed bench for route_tagger. Two instances share all inputs:
//   u_dut uses the default 8-bit counter, and u_dut_w a 2-bit counter for the
//   wrap case. The bench plays both source FIFOs with queues. A pop captured
//   in a cycle removes the head entry, and the entry is presented on
//   src*_data/dest during the following cycle.
// -----------------------------------------------------------------------------
module tb_route_tagger;

    logic       clk;
    logic       reset;
    logic       src0_empty, src1_empty;
    logic [7:0] src0_data, src1_data;
    logic [1:0] src0_dest, src1_dest;
    logic       fifo_almost_full;

    logic       pop_src0, pop_src1, push, error;
    logic [9:0] out_word;
    logic [7:0] tx_count;

    logic       pop_src0_w, pop_src1_w, push_w, error_w;
    logic [9:0] out_word_w;
    logic [1:0] tx_count_w;

    route_tagger #(.CNT_W(8)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .src0_empty       (src0_empty),
        .src1_empty       (src1_empty),
        .src0_data        (src0_data),
        .src1_data        (src1_data),
        .src0_dest        (src0_dest),
        .src1_dest        (src1_dest),
        .fifo_almost_full (fifo_almost_full),
        .pop_src0         (pop_src0),
        .pop_src1         (pop_src1),
        .out_word         (out_word),
        .push             (push),
        .error            (error),
        .tx_count         (tx_count)
    );

    route_tagger #(.CNT_W(2)) u_dut_w (
        .clk              (clk),
        .reset            (reset),
        .src0_empty       (src0_empty),
        .src1_empty       (src1_empty),
        .src0_data        (src0_data),
        .src1_data        (src1_data),
        .src0_dest        (src0_dest),
        .src1_dest        (src1_dest),
        .fifo_almost_full (fifo_almost_full),
        .pop_src0         (pop_src0_w),
        .pop_src1         (pop_src1_w),
        .out_word         (out_word_w),
        .push             (push_w),
        .error            (error_w),
        .tx_count         (tx_count_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source FIFO contents, each entry {dest, data}
    logic [9:0] q0[$];
    logic [9:0] q1[$];

    // Logs built while stepping
    int         pop_log[$];
    logic [9:0] push_log[$];
    int         push_cyc_log[$];
    logic [1:0] cnt_w_log[$];

    // Snapshot of the current cycle, taken mid-cycle
    logic       s_pop0, s_pop1, s_push, s_err;
    logic [9:0] s_word;
    logic [7:0] s_cnt;
    logic [1:0] s_cnt_w;
    int         cyc;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sync_empty();
        src0_empty = (q0.size() == 0);
        src1_empty = (q1.size() == 0);
    endtask

    task automatic clear_logs();
        pop_log.delete();
        push_log.delete();
        push_cyc_log.delete();
        cnt_w_log.delete();
        cyc = 0;
    endtask

    // Called just after a falling edge with inputs already set for this cycle.
    // Snapshots the cycle, passes the rising edge, then plays the source
    // FIFOs' response to any pop at the following falling edge.
    task automatic step();
        #1;
        s_pop0  = pop_src0;
        s_pop1  = pop_src1;
        s_push  = push;
        s_word  = out_word;
        s_cnt   = tx_count;
        s_cnt_w = tx_count_w;
        s_err   = error;
        check("pop_exclusive", {31'b0, s_pop0 & s_pop1}, 32'd0);
        check("no_pop_when_empty", {30'b0, s_pop0 & src0_empty, s_pop1 & src1_empty}, 32'd0);
        if (s_pop0) pop_log.push_back(0);
        if (s_pop1) pop_log.push_back(1);
        if (s_push) begin
            push_log.push_back(s_word);
            push_cyc_log.push_back(cyc);
            cnt_w_log.push_back(s_cnt_w);
        end
        @(negedge clk);
        if (s_pop0 && q0.size() > 0) {src0_dest, src0_data} = q0.pop_front();
        if (s_pop1 && q1.size() > 0) {src1_dest, src1_data} = q1.pop_front();
        sync_empty();
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        clear_logs();
    endtask

    logic [9:0] exp_rr[8];

    initial begin
        reset            = 1'b1;
        fifo_almost_full = 1'b0;
        src0_data        = 8'h00;
        src1_data        = 8'h00;
        src0_dest        = 2'b00;
        src1_dest        = 2'b00;
        clear_logs();

        // ---------------- T1: reset ----------------
        q0 = '{10'h001};
        q1 = '{10'h102};
        sync_empty();
        @(negedge clk);
        step();
        check("t1_pop0_rst", {31'b0, s_pop0}, 32'd0);
        check("t1_pop1_rst", {31'b0, s_pop1}, 32'd0);
        check("t1_push_rst", {31'b0, s_push}, 32'd0);
        check("t1_word_rst", {22'b0, s_word}, 32'd0);
        check("t1_cnt_rst",  {24'b0, s_cnt},  32'd0);
        check("t1_err_rst",  {31'b0, s_err},  32'd0);
        step();
        check("t1_nopop_rst2", {30'b0, s_pop0, s_pop1}, 32'd0);
        reset = 1'b0;
        step();
        check("t1_first_pop", {30'b0, s_pop0, s_pop1}, 32'b10);
        step();
        check("t1_second_pop", {30'b0, s_pop0, s_pop1}, 32'b01);
        repeat (4) step();

        // ---------------- T2: single source ----------------
        do_reset();
        q0 = '{10'h0A5, 10'h13C};
        sync_empty();
        step();
        check("t2_c0_pop0", {31'b0, s_pop0}, 32'd1);
        step();
        check("t2_c1_pop0", {31'b0, s_pop0}, 32'd1);
        check("t2_c1_push", {31'b0, s_push}, 32'd0);
        step();
        check("t2_c2_pop0", {31'b0, s_pop0}, 32'd0);
        check("t2_c2_push", {31'b0, s_push}, 32'd1);
        check("t2_c2_word", {22'b0, s_word}, 32'h0A5);
        check("t2_c2_cnt",  {24'b0, s_cnt},  32'd1);
        step();
        check("t2_c3_push", {31'b0, s_push}, 32'd1);
        check("t2_c3_word", {22'b0, s_word}, 32'h13C);
        check("t2_c3_cnt",  {24'b0, s_cnt},  32'd2);
        step();
        check("t2_c4_idle_push", {31'b0, s_push}, 32'd0);
        check("t2_c4_word_hold", {22'b0, s_word}, 32'h13C);
        check("t2_c4_cnt",       {24'b0, s_cnt},  32'd2);

        // ---------------- T3: round robin ----------------
        exp_rr = '{10'h010, 10'h120, 10'h111, 10'h021,
                   10'h012, 10'h122, 10'h113, 10'h023};
        do_reset();
        q0 = '{10'h010, 10'h111, 10'h012, 10'h113};
        q1 = '{10'h120, 10'h021, 10'h122, 10'h023};
        sync_empty();
        repeat (12) step();
        check("t3_pop_count", pop_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < pop_log.size(); i++)
            check($sformatf("t3_pop_order_%0d", i), pop_log[i], i % 2);
        check("t3_push_count", push_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < push_log.size(); i++)
            check($sformatf("t3_push_word_%0d", i), {22'b0, push_log[i]}, {22'b0, exp_rr[i]});
        if (push_cyc_log.size() == 8) begin
            check("t3_first_push_cyc", push_cyc_log[0], 32'd2);
            check("t3_contiguous", push_cyc_log[7] - push_cyc_log[0], 32'd7);
        end
        check("t3_cnt", {24'b0, s_cnt}, 32'd8);

        // ---------------- T4: backpressure ----------------
        do_reset();
        q0 = '{10'h010, 10'h111, 10'h012, 10'h113};
        q1 = '{10'h120, 10'h021, 10'h122, 10'h023};
        sync_empty();
        repeat (3) step();
        check("t4_pops_before_af", pop_log.size(), 32'd3);
        fifo_almost_full = 1'b1;
        begin
            int pushes_in_af;
            pushes_in_af = 0;
            for (int i = 0; i < 4; i++) begin
                step();
                check($sformatf("t4_no_pop_af_%0d", i), {30'b0, s_pop0, s_pop1}, 32'd0);
                if (s_push) pushes_in_af++;
            end
            check("t4_drain_pushes", pushes_in_af, 32'd2);
        end
        fifo_almost_full = 1'b0;
        step();
        check("t4_resume_pop1", {30'b0, s_pop0, s_pop1}, 32'b01);
        repeat (9) step();
        check("t4_push_count", push_log.size(), 32'd8);
        for (int i = 0; i < 8 && i < push_log.size(); i++)
            check($sformatf("t4_push_word_%0d", i), {22'b0, push_log[i]}, {22'b0, exp_rr[i]});
        check("t4_cnt", {24'b0, s_cnt}, 32'd8);

        // ---------------- T5: illegal destination ----------------
        do_reset();
        q1 = '{10'h277, 10'h111};
        sync_empty();
        step();
        check("t5_c0_pop1", {30'b0, s_pop0, s_pop1}, 32'b01);
        step();
        check("t5_c1_pop1", {30'b0, s_pop0, s_pop1}, 32'b01);
        step();
        check("t5_c2_dropped", {31'b0, s_push}, 32'd0);
        check("t5_c2_word",    {22'b0, s_word}, 32'd0);
        check("t5_c2_err",     {31'b0, s_err},  32'd1);
        check("t5_c2_cnt",     {24'b0, s_cnt},  32'd0);
        step();
        check("t5_c3_push", {31'b0, s_push}, 32'd1);
        check("t5_c3_word", {22'b0, s_word}, 32'h111);
        check("t5_c3_cnt",  {24'b0, s_cnt},  32'd1);
        repeat (3) step();
        check("t5_err_sticky", {31'b0, s_err}, 32'd1);
        check("t5_cnt_final",  {24'b0, s_cnt}, 32'd1);

        // ---------------- T6: counter wrap and mid-stream reset ----------------
        do_reset();
        step();
        check("t6_err_cleared", {31'b0, s_err}, 32'd0);
        q0 = '{10'h001, 10'h002, 10'h003, 10'h004, 10'h005};
        sync_empty();
        repeat (8) step();
        check("t6_push_count", push_log.size(), 32'd5);
        begin
            logic [1:0] exp_wrap[5];
            exp_wrap = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
            for (int i = 0; i < 5 && i < cnt_w_log.size(); i++)
                check($sformatf("t6_wrap_%0d", i), {30'b0, cnt_w_log[i]}, {30'b0, exp_wrap[i]});
        end
        check("t6_cnt8", {24'b0, s_cnt}, 32'd5);

        clear_logs();
        q0 = '{10'h031, 10'h032, 10'h033, 10'h034};
        sync_empty();
        repeat (3) step();
        check("t6_midstream_push", {31'b0, s_push}, 32'd1);
        reset = 1'b1;
        step();
        check("t6_rst_no_pop", {30'b0, s_pop0, s_pop1}, 32'd0);
        step();
        check("t6_rst_push0",  {31'b0, s_push},  32'd0);
        check("t6_rst_cnt8",   {24'b0, s_cnt},   32'd0);
        check("t6_rst_cnt2",   {30'b0, s_cnt_w}, 32'd0);
        check("t6_rst_word",   {22'b0, s_word},  32'd0);
        reset = 1'b0;
        q0.delete();
        sync_empty();
        step();
        check("t6_no_partial_word", {31'b0, s_push}, 32'd0);
        step();
        check("t6_still_idle", {31'b0, s_push}, 32'd0);
        check("t6_cnt_after", {24'b0, s_cnt}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
